serialtopar: RTL

- Serial-to-parallel receiver: the far end of the 8-bit MSB-first serial link driven at clk_32f.
- Idle frames on the link carry the comma byte 0xBC; payload bytes are all other values.
- The block finds byte alignment by hunting for the comma, then requires BC_LOCK consecutive aligned commas before declaring the link active.
- Once active, it presents each non-comma byte as an 8-bit word with a one-cycle valid strobe.

---
 rtl/serialtopar.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serialtopar.sv
// serialtopar: MSB-first serial receiver with comma-based byte alignment.
// Hunts for COMMA at any bit offset, locks after BC_LOCK aligned commas.
module serialtopar #(
  parameter logic [7:0]  COMMA   = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [3:0] bc_count
);

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    ACTIVE
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(BC_LOCK);
  localparam logic       LOCK_ONE = (BC_LOCK == 1);

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] data_n;
  logic       valid_n;
  logic       active_n;
  logic [3:0] bc_n;

  logic [7:0] word_next;
  logic       is_comma;
  logic       boundary;
  logic [3:0] bc_inc;

  assign word_next = {shift[6:0], data_in};
  assign is_comma  = (word_next == COMMA);
  assign boundary  = (bit_cnt == 3'd7);
  assign bc_inc    = bc_count + 4'd1;

  always_comb begin
    state_n   = state;
    shift_n   = word_next;
    bit_cnt_n = bit_cnt;
    data_n    = data_out;
    valid_n   = 1'b0;
    active_n  = active;
    bc_n      = bc_count;
    unique case (state)
      SEARCH: begin
        bit_cnt_n = 3'd0;
        if (is_comma) begin
          bc_n = 4'd1;
          if (LOCK_ONE) begin
            state_n  = ACTIVE;
            active_n = 1'b1;
          end else begin
            state_n = LOCKING;
          end
        end else begin
          bc_n = 4'd0;
        end
      end
      LOCKING: begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_n = bc_inc;
            if (bc_inc == LOCK_N) begin
              state_n  = ACTIVE;
              active_n = 1'b1;
            end
          end else begin
            // next SEARCH compare happens on the following edge
            state_n   = SEARCH;
            bc_n      = 4'd0;
            bit_cnt_n = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (boundary) begin
          if (!is_comma) begin
            data_n  = word_next;
            valid_n = 1'b1;
          end else if (bc_count != 4'hF) begin
            bc_n = bc_inc;
          end
        end
      end
      default: begin
        state_n   = SEARCH;
        bit_cnt_n = 3'd0;
        active_n  = 1'b0;
        bc_n      = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state     <= SEARCH;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      bc_count  <= 4'd0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      active    <= active_n;
      bc_count  <= bc_n;
    end
  end

endmodule
